// File: rtl/msgpass_buff_rd_sched_if.sv
// Read-port A sequencing bundle for the message-pass buffer.
// Master drives window control and conflict flags; slave drives the read port.
interface msgpass_buff_rd_sched_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DRC_NUM    = 1
);
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   len_i;
  logic                  abort_i;
  logic [DRC_NUM-1:0]    is_drc_i;
  logic [ADDR_WIDTH-1:0] raddr_o;
  logic                  cen_o;
  logic                  scu_busy_o;
  logic                  done_o;

  modport master (
    output start_i, base_addr_i, len_i,
    output abort_i, is_drc_i,
    input  raddr_o, cen_o, scu_busy_o, done_o
  );

  modport slave (
    input  start_i, base_addr_i, len_i,
    input  abort_i, is_drc_i,
    output raddr_o, cen_o, scu_busy_o, done_o
  );
endinterface

// File: rtl/msgpass_buff_rd_sched.sv
// Streams a programmed window of buffer entries out of read port A,
// holding the stream while memShare reports a double-request conflict.
module msgpass_buff_rd_sched #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int DRC_NUM    = 1
) (
  input logic sys_clk,
  input logic rst,
  msgpass_buff_rd_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_A =
    ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [ADDR_WIDTH:0]   lenClamp;
  logic                  zeroHold;
  logic                  drc;
  logic                  readEn;

  assign drc = |bus.is_drc_i;

  assign lenClamp = (bus.len_i > DEPTH_W) ?
    DEPTH_W : bus.len_i;

  // wrap at DEPTH, which may be below 2**ADDR_WIDTH
  assign nextAddr = (raddr == LAST_A) ?
    '0 : raddr + ONE_A;

  assign readEn = (state == STREAM) &&
    !drc && !bus.abort_i;

  assign bus.raddr_o    = raddr;
  assign bus.cen_o      = readEn;
  assign bus.scu_busy_o = (state != IDLE);
  assign bus.done_o     = (state == DONE) &&
    !zeroHold && !bus.abort_i;

  // zeroHold pads an empty window so it still
  // takes two cycles from start to done
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      raddr     <= '0;
      remaining <= '0;
      zeroHold  <= 1'b0;
    end else if (bus.abort_i && state != IDLE) begin
      state     <= IDLE;
      remaining <= '0;
      zeroHold  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            if (lenClamp == '0) begin
              state    <= DONE;
              zeroHold <= 1'b1;
            end else begin
              state     <= STREAM;
              raddr     <= bus.base_addr_i;
              remaining <= lenClamp;
            end
          end
        end
        STREAM: begin
          if (readEn) begin
            raddr     <= nextAddr;
            remaining <= remaining - ONE_W;
            if (remaining == ONE_W)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!drc)
            state <= DONE;
        end
        DONE: begin
          if (zeroHold)
            zeroHold <= 1'b0;
          else
            state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msgpass_buff_rd_sched.sv
// Directed cycle-by-cycle checks of the buffer read sequencer.
// Expected per-cycle masks are hand-derived from the window timing.
module tb_msgpass_buff_rd_sched;

  localparam int AW = 4;
  localparam int DN = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks  = 0;
  int   passCnt = 0;
  int   curCyc  = 0;

  msgpass_buff_rd_sched_if #(
    .ADDR_WIDTH(AW),
    .DRC_NUM(DN)
  ) bus ();

  msgpass_buff_rd_sched #(
    .ADDR_WIDTH(AW),
    .DEPTH(16),
    .DRC_NUM(DN)
  ) dut (
    .sys_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    string tag,
    logic [31:0] obs,
    logic [31:0] exp
  );
    checks++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h",
                tag, curCyc, obs, exp);
  endtask

  // cycle 0 is the start cycle; bit c of each mask is cycle c
  task automatic runSeq(
    string        tag,
    logic [3:0]   base,
    logic [4:0]   len,
    int           n,
    logic [31:0]  stM,
    logic [31:0]  drcM,
    logic [31:0]  abM,
    logic [31:0]  cenM,
    logic [31:0]  busyM,
    logic [31:0]  doneM,
    logic [127:0] ra,
    logic [31:0]  raCare
  );
    for (int c = 0; c < n; c++) begin
      tick();
      curCyc          = c;
      bus.start_i     = stM[c];
      bus.base_addr_i = (c == 0) ? base : ~base;
      bus.len_i       = (c == 0) ? len : 5'd1;
      bus.is_drc_i    = drcM[c];
      bus.abort_i     = abM[c];
      #1;
      chk({tag, ".cen"}, 32'(bus.cen_o), 32'(cenM[c]));
      chk({tag, ".busy"}, 32'(bus.scu_busy_o),
          32'(busyM[c]));
      chk({tag, ".done"}, 32'(bus.done_o), 32'(doneM[c]));
      if (raCare[c])
        chk({tag, ".raddr"}, 32'(bus.raddr_o),
            32'(ra[4*c +: 4]));
    end
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.len_i       = '0;
    bus.abort_i     = 1'b0;
    bus.is_drc_i    = '0;

    tick();
    chk("rst.cen", 32'(bus.cen_o), 32'd0);
    chk("rst.busy", 32'(bus.scu_busy_o), 32'd0);
    chk("rst.done", 32'(bus.done_o), 32'd0);
    chk("rst.raddr", 32'(bus.raddr_o), 32'd0);
    rst = 1'b0;

    // plain stream, drc in DONE ignored
    runSeq("plain", 4'd0, 5'd5, 9,
           32'h1, 32'h80, 32'h0,
           32'h3E, 32'hFE, 32'h80,
           128'h555432100, 32'h1FE);

    // conflict in second stream cycle
    runSeq("stall", 4'd0, 5'd5, 10,
           32'h1, 32'h4, 32'h0,
           32'h7A, 32'h1FE, 32'h100,
           128'h5554321100, 32'h3FE);

    // conflict held two cycles in DRAIN
    runSeq("drain", 4'd0, 5'd3, 9,
           32'h1, 32'h30, 32'h0,
           32'h0E, 32'hFE, 32'h80,
           128'h333332100, 32'h1FE);

    runSeq("wrap", 4'd14, 5'd4, 8,
           32'h1, 32'h0, 32'h0,
           32'h1E, 32'h7E, 32'h40,
           128'h22210FE0, 32'hFE);

    // empty window: no read, address untouched
    runSeq("len0", 4'd7, 5'd0, 4,
           32'h1, 32'h0, 32'h0,
           32'h0, 32'h6, 32'h4,
           128'h2220, 32'hE);

    // 20 clamps to 16 entries
    runSeq("clamp", 4'd0, 5'd20, 20,
           32'h1, 32'h0, 32'h0,
           32'h1FFFE, 32'h7FFFE, 32'h40000,
           128'h000FEDCBA98765432100, 32'hFFFFE);

    runSeq("abort", 4'd3, 5'd5, 6,
           32'h1, 32'h0, 32'h8,
           32'h6, 32'hE, 32'h0,
           128'h555430, 32'h3E);

    // start pulses in STREAM and DONE are ignored
    runSeq("restart", 4'd0, 5'd3, 7,
           32'h25, 32'h0, 32'h0,
           32'hE, 32'h3E, 32'h20,
           128'h3332100, 32'h7E);

    // reset mid-window after two reads
    runSeq("rstmid", 4'd2, 5'd5, 3,
           32'h1, 32'h0, 32'h0,
           32'h6, 32'h6, 32'h0,
           128'h320, 32'h6);
    tick();
    curCyc       = 3;
    bus.start_i  = 1'b0;
    bus.is_drc_i = '0;
    bus.abort_i  = 1'b0;
    #1;
    chk("rstmid.pre", 32'(bus.raddr_o), 32'd4);
    rst = 1'b1;
    #1;
    chk("rstmid.cen", 32'(bus.cen_o), 32'd0);
    chk("rstmid.busy", 32'(bus.scu_busy_o), 32'd0);
    chk("rstmid.done", 32'(bus.done_o), 32'd0);
    chk("rstmid.raddr", 32'(bus.raddr_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    curCyc = 5;
    chk("rstmid.idle", 32'(bus.scu_busy_o), 32'd0);
    chk("rstmid.nodone", 32'(bus.done_o), 32'd0);

    $display("%0d/%0d checks passed", passCnt, checks);
    $finish;
  end

endmodule
